// File: rtl/vmicro16_wb_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : vmicro16_wb_arbiter_pkg
//  Description : Shared definitions for the vmicro16 Wishbone arbiter:
//                arbiter state encoding, default watchdog limit and a
//                constant ceil(log2()) helper for sizing counters.
//  Revision    : 1.0 - initial release
// ============================================================================
package vmicro16_wb_arbiter_pkg;

    typedef enum logic [0:0] {
        ARB_IDLE = 1'b0,
        ARB_BUSY = 1'b1
    } arb_state_t;

    // Watchdog limit, in stalled bus cycles, used when the timeout is built in.
    localparam int C_DEF_TIMEOUT = 15;

    // ceil(log2(value)); returns 0 for value <= 1.
    function automatic int clog2(input int value);
        int r;
        int v;
        r = 0;
        v = value - 1;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/vmicro16_rr_pick.sv
`default_nettype none
// ============================================================================
//  Module      : vmicro16_rr_pick
//  Description : Combinational round-robin priority picker. Scans the
//                request vector starting at last_idx+1 (wrapping modulo
//                N_MASTERS) and returns the first requester found.
//  Ports       : req      - per-master request vector
//                last_idx - index that was served last (lowest priority)
//                valid    - at least one request is present
//                idx      - index of the winning requester
//  Revision    : 1.0 - initial release
// ============================================================================
module vmicro16_rr_pick #(
    parameter int N_MASTERS = 4,
    parameter int SEL_BITS  = 2
) (
    input  logic [N_MASTERS-1:0] req,
    input  logic [SEL_BITS-1:0]  last_idx,
    output logic                 valid,
    output logic [SEL_BITS-1:0]  idx
);

    logic [SEL_BITS:0] w_sum;
    logic [SEL_BITS:0] w_cand;

    always_comb begin
        valid  = 1'b0;
        idx    = '0;
        w_sum  = '0;
        w_cand = '0;
        // Walk from the lowest-priority offset to the highest so that the
        // requester nearest after last_idx is written last and wins.
        for (int i = N_MASTERS; i >= 1; i--) begin
            w_sum  = {1'b0, last_idx} + (SEL_BITS + 1)'(i);
            w_cand = (w_sum >= (SEL_BITS + 1)'(N_MASTERS)) ?
                     (w_sum - (SEL_BITS + 1)'(N_MASTERS)) : w_sum;
            if (req[w_cand[SEL_BITS-1:0]]) begin
                valid = 1'b1;
                idx   = w_cand[SEL_BITS-1:0];
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/vmicro16_wb_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : vmicro16_wb_arbiter
//  Description : Round-robin Wishbone arbiter sharing one slave port between
//                N_MASTERS vmicro16 cores. The grant is held for the whole
//                cyc-framed bus cycle; release hands over back-to-back.
//  Ports       : clk, reset (async, active-low)
//                m_*_i / m_*_o - packed per-master Wishbone master ports
//                s_*_o / s_*_i - single shared slave port
//                grant_o       - registered one-hot grant, 0 when idle
//  Options     : define VMICRO16_WB_ARB_TIMEOUT_EN to build in a watchdog
//                that errors and releases a master whose slave does not
//                respond within TIMEOUT stalled cycles.
//  Revision    : 1.0 - initial release
// ============================================================================
module vmicro16_wb_arbiter
    import vmicro16_wb_arbiter_pkg::*;
#(
    parameter int N_MASTERS  = 4,
    parameter int SEL_BITS   = 2,
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 16,
    parameter int TIMEOUT    = C_DEF_TIMEOUT
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [N_MASTERS-1:0]             m_cyc_i,
    input  logic [N_MASTERS-1:0]             m_stb_i,
    input  logic [N_MASTERS-1:0]             m_we_i,
    input  logic [N_MASTERS*ADDR_WIDTH-1:0]  m_addr_i,
    input  logic [N_MASTERS*DATA_WIDTH-1:0]  m_data_i,
    output logic [DATA_WIDTH-1:0]            m_data_o,
    output logic [N_MASTERS-1:0]             m_ack_o,
    output logic [N_MASTERS-1:0]             m_stall_o,
    output logic [N_MASTERS-1:0]             m_err_o,
    output logic                             s_cyc_o,
    output logic                             s_stb_o,
    output logic                             s_we_o,
    output logic [ADDR_WIDTH-1:0]            s_addr_o,
    output logic [DATA_WIDTH-1:0]            s_data_o,
    input  logic [DATA_WIDTH-1:0]            s_data_i,
    input  logic                             s_ack_i,
    input  logic                             s_stall_i,
    input  logic                             s_err_i,
    output logic [N_MASTERS-1:0]             grant_o
);

    arb_state_t            r_state_q,    w_state_d;
    logic [SEL_BITS-1:0]   r_gnt_idx_q,  w_gnt_idx_d;
    logic [SEL_BITS-1:0]   r_last_idx_q, w_last_idx_d;
    logic [N_MASTERS-1:0]  r_grant_q,    w_grant_d;

    logic                  w_busy;
    logic                  w_release;
    logic                  w_timeout;
    logic [N_MASTERS-1:0]  w_pick_req;
    logic [SEL_BITS-1:0]   w_pick_last;
    logic                  w_pick_valid;
    logic [SEL_BITS-1:0]   w_pick_idx;
    logic [N_MASTERS-1:0]  w_pick_oh;

    assign w_busy    = (r_state_q == ARB_BUSY);
    assign w_release = w_busy & (~m_cyc_i[r_gnt_idx_q] | w_timeout);

    // While busy the picker only matters on a release; the current owner is
    // masked out and treated as last served, so a forced (timeout) release
    // never re-grants the same master in the same cycle.
    assign w_pick_req  = w_busy ? (m_cyc_i & ~r_grant_q) : m_cyc_i;
    assign w_pick_last = w_busy ? r_gnt_idx_q : r_last_idx_q;
    assign w_pick_oh   = {{(N_MASTERS-1){1'b0}}, 1'b1} << w_pick_idx;

    vmicro16_rr_pick #(
        .N_MASTERS (N_MASTERS),
        .SEL_BITS  (SEL_BITS)
    ) u_rr_pick (
        .req      (w_pick_req),
        .last_idx (w_pick_last),
        .valid    (w_pick_valid),
        .idx      (w_pick_idx)
    );

`ifdef VMICRO16_WB_ARB_TIMEOUT_EN
    localparam int C_TO_W = clog2(TIMEOUT + 1);

    logic [C_TO_W-1:0] r_to_cnt_q, w_to_cnt_d;
    logic              w_resp;

    assign w_resp = s_ack_i | s_err_i;

    // Fires on the TIMEOUT-th consecutive strobed cycle without a response.
    assign w_timeout = w_busy & m_stb_i[r_gnt_idx_q] & ~w_resp &
                       (r_to_cnt_q == C_TO_W'(TIMEOUT - 1));

    always_comb begin
        w_to_cnt_d = r_to_cnt_q;
        if (!w_busy || w_release || w_resp) begin
            w_to_cnt_d = '0;
        end else if (m_stb_i[r_gnt_idx_q]) begin
            w_to_cnt_d = r_to_cnt_q + C_TO_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_to_cnt_q <= '0;
        end else begin
            r_to_cnt_q <= w_to_cnt_d;
        end
    end
`else
    // Watchdog compiled out; TIMEOUT is a non-negative limit so this is 0.
    assign w_timeout = (TIMEOUT < 0);
`endif

    always_comb begin
        w_state_d    = r_state_q;
        w_gnt_idx_d  = r_gnt_idx_q;
        w_last_idx_d = r_last_idx_q;
        w_grant_d    = r_grant_q;
        case (r_state_q)
            ARB_IDLE: begin
                if (w_pick_valid) begin
                    w_state_d   = ARB_BUSY;
                    w_gnt_idx_d = w_pick_idx;
                    w_grant_d   = w_pick_oh;
                end
            end
            ARB_BUSY: begin
                if (w_release) begin
                    w_last_idx_d = r_gnt_idx_q;
                    if (w_pick_valid) begin
                        w_gnt_idx_d = w_pick_idx;
                        w_grant_d   = w_pick_oh;
                    end else begin
                        w_state_d = ARB_IDLE;
                        w_grant_d = '0;
                    end
                end
            end
            default: begin
                w_state_d = ARB_IDLE;
                w_grant_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state_q    <= ARB_IDLE;
            r_gnt_idx_q  <= '0;
            r_last_idx_q <= SEL_BITS'(N_MASTERS - 1);
            r_grant_q    <= '0;
        end else begin
            r_state_q    <= w_state_d;
            r_gnt_idx_q  <= w_gnt_idx_d;
            r_last_idx_q <= w_last_idx_d;
            r_grant_q    <= w_grant_d;
        end
    end

    assign grant_o = r_grant_q;

    // Routing is an indexed select on the registered grant, so fields of
    // non-granted masters (including X/Z) never reach the slave.
    always_comb begin
        s_cyc_o   = 1'b0;
        s_stb_o   = 1'b0;
        s_we_o    = 1'b0;
        s_addr_o  = '0;
        s_data_o  = '0;
        m_data_o  = '0;
        m_ack_o   = '0;
        m_err_o   = '0;
        m_stall_o = {N_MASTERS{|m_cyc_i}};
        if (w_busy) begin
            s_cyc_o   = m_cyc_i[r_gnt_idx_q] & ~w_timeout;
            s_stb_o   = m_stb_i[r_gnt_idx_q] & ~w_timeout;
            s_we_o    = m_we_i[r_gnt_idx_q];
            s_addr_o  = m_addr_i[r_gnt_idx_q*ADDR_WIDTH +: ADDR_WIDTH];
            s_data_o  = m_data_i[r_gnt_idx_q*DATA_WIDTH +: DATA_WIDTH];
            m_data_o  = s_data_i;
            m_stall_o = m_cyc_i;
            m_stall_o[r_gnt_idx_q] = s_stall_i;
            // An error response takes precedence over a simultaneous ack.
            m_ack_o[r_gnt_idx_q]   = s_ack_i & ~s_err_i;
            m_err_o[r_gnt_idx_q]   = s_err_i | w_timeout;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_vmicro16_wb_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_vmicro16_wb_arbiter
//  Description : Directed self-checking bench for vmicro16_wb_arbiter with a
//                16-entry slave memory model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_vmicro16_wb_arbiter;

    localparam int N  = 4;
    localparam int AW = 16;
    localparam int DW = 16;

    logic              clk = 1'b0;
    logic              reset;
    logic [N-1:0]      m_cyc_i, m_stb_i, m_we_i;
    logic [N*AW-1:0]   m_addr_i;
    logic [N*DW-1:0]   m_data_i;
    logic [DW-1:0]     m_data_o;
    logic [N-1:0]      m_ack_o, m_stall_o, m_err_o, grant_o;
    logic              s_cyc_o, s_stb_o, s_we_o;
    logic [AW-1:0]     s_addr_o;
    logic [DW-1:0]     s_data_o, s_data_i;
    logic              s_ack_i, s_stall_i, s_err_i;

    logic [DW-1:0]     mem [16] = '{0: 16'h1234, default: 16'h0000};

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    assign s_data_i = mem[s_addr_o[3:0]];

    always @(posedge clk) begin
        if (s_cyc_o && s_stb_o && s_we_o && s_ack_i) begin
            mem[s_addr_o[3:0]] <= s_data_o;
        end
    end

    vmicro16_wb_arbiter #(
        .N_MASTERS  (N),
        .SEL_BITS   (2),
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .TIMEOUT    (15)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .m_cyc_i   (m_cyc_i),
        .m_stb_i   (m_stb_i),
        .m_we_i    (m_we_i),
        .m_addr_i  (m_addr_i),
        .m_data_i  (m_data_i),
        .m_data_o  (m_data_o),
        .m_ack_o   (m_ack_o),
        .m_stall_o (m_stall_o),
        .m_err_o   (m_err_o),
        .s_cyc_o   (s_cyc_o),
        .s_stb_o   (s_stb_o),
        .s_we_o    (s_we_o),
        .s_addr_o  (s_addr_o),
        .s_data_o  (s_data_o),
        .s_data_i  (s_data_i),
        .s_ack_i   (s_ack_i),
        .s_stall_i (s_stall_i),
        .s_err_i   (s_err_i),
        .grant_o   (grant_o)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        reset     = 1'b0;
        m_cyc_i   = 4'b1111;
        m_stb_i   = '0;
        m_we_i    = '0;
        m_addr_i  = '0;
        m_data_i  = '0;
        s_ack_i   = 1'b0;
        s_stall_i = 1'b0;
        s_err_i   = 1'b0;
        #2;
        // Reset state
        chk("rst_grant", grant_o, 0);
        chk("rst_scyc", s_cyc_o, 0);
        chk("rst_stall", m_stall_o, 4'b1111);
        chk("rst_ack", m_ack_o, 0);
        chk("rst_err", m_err_o, 0);
        chk("rst_data", m_data_o, 0);
        repeat (2) step();
        chk("rst_hold_grant", grant_o, 0);
        reset = 1'b1;
        step();
        chk("first_grant", grant_o, 4'b0001);
        chk("first_scyc", s_cyc_o, 1);

        // Read path on master 0 (slave word 0 holds 1234)
        m_stb_i = 4'b0001;
        s_ack_i = 1'b1;
        #1;
        chk("rd_data", m_data_o, 16'h1234);
        chk("rd_ack", m_ack_o, 4'b0001);
        chk("rd_stall", m_stall_o, 4'b1110);
        chk("rd_sstb", s_stb_o, 1);
        s_err_i = 1'b1;
        #1;
        chk("errwin_ack", m_ack_o, 4'b0000);
        chk("errwin_err", m_err_o, 4'b0001);
        s_err_i   = 1'b0;
        s_ack_i   = 1'b0;
        s_stall_i = 1'b1;
        #1;
        chk("stall_pass", m_stall_o, 4'b1111);
        s_stall_i = 1'b0;
        m_stb_i   = '0;
        step();

        // Release master 0 with others waiting: back-to-back to master 1
        m_cyc_i = 4'b1110;
        #1;
        chk("rel_scyc", s_cyc_o, 0);
        step();
        chk("b2b_grant1", grant_o, 4'b0010);

        // Rotation: 1 releases while 3 waits, then 1 comes back behind 3
        m_cyc_i = 4'b1010;
        step();
        chk("hold_grant1", grant_o, 4'b0010);
        m_cyc_i = 4'b1000;
        step();
        chk("rot_grant3", grant_o, 4'b1000);
        m_cyc_i = 4'b1010;
        step();
        chk("hold_grant3", grant_o, 4'b1000);
        m_cyc_i = 4'b0010;
        step();
        chk("rot_grant1", grant_o, 4'b0010);
        m_cyc_i = 4'b0000;
        step();
        chk("idle_grant", grant_o, 0);
        chk("idle_scyc", s_cyc_o, 0);
        chk("idle_data", m_data_o, 0);
        chk("idle_stall", m_stall_o, 0);

        // Single master write from master 2; other masters' fields are X
        m_cyc_i  = 4'b0100;
        m_stb_i  = 4'bx1xx;
        m_we_i   = 4'bx1xx;
        m_addr_i = {16'hxxxx, 16'h0003, 16'hxxxx, 16'hxxxx};
        m_data_i = {16'hxxxx, 16'hBEEF, 16'hxxxx, 16'hxxxx};
        step();
        chk("wr_grant", grant_o, 4'b0100);
        chk("wr_addr", s_addr_o, 16'h0003);
        chk("wr_data", s_data_o, 16'hBEEF);
        chk("wr_we", s_we_o, 1);
        chk("wr_stb", s_stb_o, 1);
        s_ack_i = 1'b1;
        #1;
        chk("wr_ack", m_ack_o, 4'b0100);
        step();
        s_ack_i = 1'b0;
        m_we_i  = 4'bx0xx;
        #1;
        chk("rb_we", s_we_o, 0);
        chk("rb_data", m_data_o, 16'hBEEF);

        // Reset in the middle of the access drops the bus immediately
        s_ack_i = 1'b1;
        reset   = 1'b0;
        #1;
        chk("mrst_scyc", s_cyc_o, 0);
        chk("mrst_grant", grant_o, 0);
        chk("mrst_ack", m_ack_o, 0);
        s_ack_i  = 1'b0;
        m_cyc_i  = '0;
        m_stb_i  = '0;
        m_we_i   = '0;
        m_addr_i = '0;
        m_data_i = '0;
        step();
        reset = 1'b1;

        // Contention: everyone requests, each drops cyc 2 cycles after its ack
        m_cyc_i = 4'b1111;
        m_stb_i = 4'b1111;
        step();
        for (int i = 0; i < 5; i++) begin
            k = i % 4;
            chk($sformatf("rr_grant%0d", i), grant_o, 32'd1 << k);
            s_ack_i = 1'b1;
            #1;
            chk($sformatf("rr_ack%0d", i), m_ack_o, 32'd1 << k);
            step();
            s_ack_i = 1'b0;
            step();
            m_cyc_i[k] = 1'b0;
            #1;
            chk($sformatf("rr_drop%0d", i), s_cyc_o, 0);
            step();
            m_cyc_i[k] = 1'b1;
        end
        m_cyc_i = '0;
        m_stb_i = '0;
        step();
        chk("rr_idle", grant_o, 0);

        // Hung slave: masters 2 and 0 request, slave never answers
        m_cyc_i = 4'b0101;
        m_stb_i = 4'b0101;
        step();
        chk("hang_grant", grant_o, 4'b0100);
`ifdef VMICRO16_WB_ARB_TIMEOUT_EN
        for (int i = 1; i < 15; i++) begin
            chk($sformatf("to_noerr%0d", i), m_err_o, 0);
            step();
        end
        chk("to_err", m_err_o, 4'b0100);
        chk("to_scyc", s_cyc_o, 0);
        step();
        chk("to_regrant", grant_o, 4'b0001);
        chk("to_err_once", m_err_o, 0);
        repeat (3) step();
        reset = 1'b0;
        #1;
        chk("to_rst_err", m_err_o, 0);
        chk("to_rst_scyc", s_cyc_o, 0);
        step();
        reset = 1'b1;
        step();
        chk("to_rst_grant", grant_o, 4'b0001);
        for (int i = 1; i < 15; i++) begin
            chk($sformatf("to2_noerr%0d", i), m_err_o, 0);
            step();
        end
        chk("to2_err", m_err_o, 4'b0001);
`else
        repeat (30) step();
        chk("hang_hold", grant_o, 4'b0100);
        chk("hang_scyc", s_cyc_o, 1);
        chk("hang_noerr", m_err_o, 0);
`endif
        m_cyc_i = '0;
        m_stb_i = '0;
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
